// File: rtl/data_mem_seq.sv
// data_mem_seq: clocked data memory with req/ack handshake, programmable wait states,
// boot image on reset and out-of-range flagging. Optional even parity: DMEM_PARITY_EN.
module data_mem_seq #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
`ifdef DMEM_PARITY_EN
    input  logic              inject_perr,
`endif
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] read_data_out,
    output logic              err
);

`ifdef DMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we_q;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [DATA_W-1:0]   r_wdata_q;
`ifdef DMEM_PARITY_EN
    logic                r_inj_q;
    logic                w_go_inj;
`endif
    logic [WORD_W-1:0]   r_mem [DEPTH];

    logic                w_go_we;
    logic [ADDR_W-1:0]   w_go_addr;
    logic [DATA_W-1:0]   w_go_wdata;
    logic                w_commit;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_idx;
    logic [WORD_W-1:0]   w_rd_word;
    logic [WORD_W-1:0]   w_wr_word;
    logic                w_rd_err;

    function automatic logic [WORD_W-1:0] boot_word(input int unsigned idx);
        logic [DATA_W-1:0] d;
        case (idx)
            0:       d = DATA_W'(16'h0045);
            1:       d = DATA_W'(16'h0006);
            2:       d = DATA_W'(16'h0009);
            default: d = '0;
        endcase
`ifdef DMEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // With zero wait states the access commits on the req-sampling edge itself,
    // so the commit path takes the live inputs in IDLE and the captured copy otherwise.
    assign w_go_we    = (r_state == S_IDLE) ? we         : r_we_q;
    assign w_go_addr  = (r_state == S_IDLE) ? addr       : r_addr_q;
    assign w_go_wdata = (r_state == S_IDLE) ? write_data : r_wdata_q;
    assign w_commit   = ((r_state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_in_range = ({1'b0, w_go_addr} < (ADDR_W+1)'(DEPTH));
    assign w_idx      = w_in_range ? w_go_addr : '0;
    assign w_rd_word  = r_mem[w_idx];

`ifdef DMEM_PARITY_EN
    assign w_go_inj  = (r_state == S_IDLE) ? inject_perr : r_inj_q;
    assign w_wr_word = {(^w_go_wdata) ^ w_go_inj, w_go_wdata};
    assign w_rd_err  = ^w_rd_word;
`else
    assign w_wr_word = w_go_wdata;
    assign w_rd_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_we_q        <= 1'b0;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
`ifdef DMEM_PARITY_EN
            r_inj_q       <= 1'b0;
`endif
            busy          <= 1'b0;
            ack           <= 1'b0;
            err           <= 1'b0;
            read_data_out <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= boot_word(i);
            end
        end else begin
            ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we_q    <= we;
                        r_addr_q  <= addr;
                        r_wdata_q <= write_data;
`ifdef DMEM_PARITY_EN
                        r_inj_q   <= inject_perr;
`endif
                        r_cnt     <= 4'(WAIT_CYCLES);
                        busy      <= 1'b1;
                        r_state   <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase

            if (w_commit) begin
                ack <= 1'b1;
                if (!w_in_range) begin
                    err <= 1'b1;
                    if (!w_go_we) begin
                        read_data_out <= '0;
                    end
                end else if (w_go_we) begin
                    err          <= 1'b0;
                    r_mem[w_idx] <= w_wr_word;
                end else begin
                    err           <= w_rd_err;
                    read_data_out <= w_rd_word[DATA_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_seq.sv
// Self-checking bench for data_mem_seq: directed scenarios plus randomized accesses
// against an array-based reference model. Define DMEM_PARITY_EN to cover parity.
module tb_data_mem_seq;

    localparam int DEPTH_A = 6;
    localparam int WAIT_A  = 1;
`ifdef DMEM_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_a = 1'b0, we_a = 1'b0, inj_a = 1'b0;
    logic [2:0]  addr_a = '0;
    logic [15:0] wd_a = '0;
    logic        busy_a, ack_a, err_a;
    logic [15:0] rd_a;

    logic        req_b = 1'b0, we_b = 1'b0, inj_b = 1'b0;
    logic [2:0]  addr_b = '0;
    logic [15:0] wd_b = '0;
    logic        busy_b, ack_b, err_b;
    logic [15:0] rd_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mA [8];
    bit          pA [8];
    logic [15:0] eA_rd;
    logic [15:0] mB [8];
    logic [15:0] eB_rd;

    always #5 clk = ~clk;

    data_mem_seq #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)) dut (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .write_data(wd_a),
`ifdef DMEM_PARITY_EN
        .inject_perr(inj_a),
`endif
        .busy(busy_a), .ack(ack_a), .read_data_out(rd_a), .err(err_a)
    );

    data_mem_seq #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .write_data(wd_b),
`ifdef DMEM_PARITY_EN
        .inject_perr(inj_b),
`endif
        .busy(busy_b), .ack(ack_b), .read_data_out(rd_b), .err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mA[i] = '0; pA[i] = 1'b0; mB[i] = '0;
        end
        mA[0] = 16'h0045; mA[1] = 16'h0006; mA[2] = 16'h0009;
        mB[0] = 16'h0045; mB[1] = 16'h0006; mB[2] = 16'h0009;
        eA_rd = '0;
        eB_rd = '0;
    endtask

    // One complete access on the WAIT_A instance, checked against the model.
    task automatic do_acc(input bit w, input int a, input logic [15:0] d, input bit inj);
        int n;
        bit e_err;
        @(negedge clk);
        req_a = 1'b1; we_a = w; addr_a = 3'(a); wd_a = d; inj_a = inj;
        @(posedge clk); #1;
        req_a = 1'b0; we_a = ~w; addr_a = 3'($urandom); wd_a = 16'($urandom); inj_a = ~inj;
        check_eq("busy_start", {31'd0, busy_a}, 32'd1);
        n = 0;
        while (!ack_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", n, WAIT_A);
        if (a >= DEPTH_A) begin
            e_err = 1'b1;
            if (!w) eA_rd = '0;
        end else if (w) begin
            mA[a] = d;
            pA[a] = inj && PAR_ON;
            e_err = 1'b0;
        end else begin
            eA_rd = mA[a];
            e_err = pA[a];
        end
        check_eq("busy_ack", {31'd0, busy_a}, 32'd1);
        check_eq($sformatf("rdata_a%0d", a), {16'd0, rd_a}, {16'd0, eA_rd});
        check_eq($sformatf("err_a%0d", a), {31'd0, err_a}, {31'd0, e_err});
        @(posedge clk); #1;
        check_eq("ack_drop", {31'd0, ack_a}, 32'd0);
        check_eq("busy_drop", {31'd0, busy_a}, 32'd0);
    endtask

    initial begin
        bit          cw;
        logic [2:0]  ca;
        logic [15:0] cd;
        bit          exp_act;

        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_ack", {31'd0, ack_a}, 32'd0);
        check_eq("rst_err", {31'd0, err_a}, 32'd0);
        check_eq("rst_rdata", {16'd0, rd_a}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) do_acc(1'b0, i, 16'h0, 1'b0);

        do_acc(1'b1, 5, 16'hBEEF, 1'b0);
        do_acc(1'b0, 5, 16'h0, 1'b0);

        do_acc(1'b1, 7, 16'h5A5A, 1'b0);
        do_acc(1'b0, 7, 16'h0, 1'b0);
        for (int i = 0; i < DEPTH_A; i++) do_acc(1'b0, i, 16'h0, 1'b0);

`ifdef DMEM_PARITY_EN
        do_acc(1'b1, 3, 16'h1234, 1'b1);
        do_acc(1'b0, 3, 16'h0, 1'b0);
        do_acc(1'b1, 3, 16'h1234, 1'b0);
        do_acc(1'b0, 3, 16'h0, 1'b0);
`endif

        for (int i = 0; i < 40; i++)
            do_acc(1'($urandom), int'($urandom_range(0, 7)), 16'($urandom), 1'($urandom));

        // Zero-wait instance with req held high: one access every second edge.
        @(negedge clk);
        req_b = 1'b1;
        cw = 1'($urandom); ca = 3'($urandom); cd = 16'($urandom);
        we_b = cw; addr_b = ca; wd_b = cd;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            exp_act = (k % 2 == 0);
            if (exp_act) begin
                if (cw) mB[ca] = cd;
                else    eB_rd = mB[ca];
            end
            check_eq($sformatf("held_ack%0d", k), {31'd0, ack_b}, {31'd0, exp_act});
            check_eq($sformatf("held_busy%0d", k), {31'd0, busy_b}, {31'd0, exp_act});
            check_eq($sformatf("held_rdata%0d", k), {16'd0, rd_b}, {16'd0, eB_rd});
            check_eq($sformatf("held_err%0d", k), {31'd0, err_b}, 32'd0);
            @(negedge clk);
            cw = 1'($urandom); ca = 3'($urandom); cd = 16'($urandom);
            we_b = cw; addr_b = ca; wd_b = cd;
        end
        req_b = 1'b0;

        // Reset while a write to word 4 is waiting must abort it.
        do_acc(1'b1, 1, 16'h7777, 1'b0);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd4; wd_a = 16'hABCD;
        @(posedge clk); #1;
        req_a = 1'b0;
        check_eq("abort_busy_pre", {31'd0, busy_a}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("abort_busy", {31'd0, busy_a}, 32'd0);
        check_eq("abort_ack", {31'd0, ack_a}, 32'd0);
        check_eq("abort_rdata", {16'd0, rd_a}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        do_acc(1'b0, 4, 16'h0, 1'b0);
        do_acc(1'b0, 0, 16'h0, 1'b0);
        do_acc(1'b0, 1, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
